// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: reservation station in front of the single ALU.
// Holds decoded ALU ops in a compacting age-ordered queue (slot 0 oldest),
// captures CDB broadcasts, and issues the oldest ready op through a
// registered valid/ready issue stage so at most one op is in flight.
module rs_issue_scheduler #(
  parameter int RS_ENTRIES   = 4,
  parameter int TAG_WIDTH    = 4,
  parameter int VAL_WIDTH    = 64,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                              in_clk,
  input  logic                              in_rst_n,
  input  logic                              in_flush,
  input  logic                              in_disp_valid,
  output logic                              out_disp_ready,
  input  logic [ALU_OP_WIDTH-1:0]           in_disp_alu_op,
  input  logic                              in_disp_set_cc,
  input  logic [TAG_WIDTH-1:0]              in_disp_dst_tag,
  input  logic                              in_disp_src1_rdy,
  input  logic                              in_disp_src2_rdy,
  input  logic [TAG_WIDTH-1:0]              in_disp_src1_tag,
  input  logic [TAG_WIDTH-1:0]              in_disp_src2_tag,
  input  logic [VAL_WIDTH-1:0]              in_disp_src1_val,
  input  logic [VAL_WIDTH-1:0]              in_disp_src2_val,
  input  logic                              in_cdb_valid,
  input  logic [TAG_WIDTH-1:0]              in_cdb_tag,
  input  logic [VAL_WIDTH-1:0]              in_cdb_val,
  output logic                              out_issue_valid,
  input  logic                              in_issue_ready,
  output logic [ALU_OP_WIDTH-1:0]           out_issue_alu_op,
  output logic                              out_issue_set_cc,
  output logic [TAG_WIDTH-1:0]              out_issue_dst_tag,
  output logic [VAL_WIDTH-1:0]              out_issue_val_a,
  output logic [VAL_WIDTH-1:0]              out_issue_val_b,
  output logic [$clog2(RS_ENTRIES+1)-1:0]   out_occupancy
);

  localparam int OCC_W = $clog2(RS_ENTRIES + 1);
  localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  // Registered station state; validity is implied by slot index < occupancy.
  logic [OCC_W-1:0]        occ_reg, occ_next, occ_after;
  logic [ALU_OP_WIDTH-1:0] op_reg     [RS_ENTRIES];
  logic [ALU_OP_WIDTH-1:0] op_next    [RS_ENTRIES];
  logic                    cc_reg     [RS_ENTRIES];
  logic                    cc_next    [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]    dst_reg    [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]    dst_next   [RS_ENTRIES];
  logic                    s1_rdy_reg [RS_ENTRIES];
  logic                    s1_rdy_next[RS_ENTRIES];
  logic [TAG_WIDTH-1:0]    s1_tag_reg [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]    s1_tag_next[RS_ENTRIES];
  logic [VAL_WIDTH-1:0]    s1_val_reg [RS_ENTRIES];
  logic [VAL_WIDTH-1:0]    s1_val_next[RS_ENTRIES];
  logic                    s2_rdy_reg [RS_ENTRIES];
  logic                    s2_rdy_next[RS_ENTRIES];
  logic [TAG_WIDTH-1:0]    s2_tag_reg [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]    s2_tag_next[RS_ENTRIES];
  logic [VAL_WIDTH-1:0]    s2_val_reg [RS_ENTRIES];
  logic [VAL_WIDTH-1:0]    s2_val_next[RS_ENTRIES];

  // Per-slot view after this cycle's CDB capture, and registered readiness.
  logic                    w1_rdy [RS_ENTRIES];
  logic [VAL_WIDTH-1:0]    w1_val [RS_ENTRIES];
  logic                    w2_rdy [RS_ENTRIES];
  logic [VAL_WIDTH-1:0]    w2_val [RS_ENTRIES];
  logic [RS_ENTRIES-1:0]   ent_ready;

  logic                    sel_any, sel_fire, disp_fire;
  logic [IDX_W-1:0]        sel_idx;
  logic                    d1_rdy, d2_rdy;
  logic [VAL_WIDTH-1:0]    d1_val, d2_val;

  genvar gi;
  generate
    for (gi = 0; gi < RS_ENTRIES; gi++) begin : g_wake
      logic hit1, hit2;
      assign hit1 = in_cdb_valid & ~s1_rdy_reg[gi] & (s1_tag_reg[gi] == in_cdb_tag);
      assign hit2 = in_cdb_valid & ~s2_rdy_reg[gi] & (s2_tag_reg[gi] == in_cdb_tag);
      assign w1_rdy[gi] = s1_rdy_reg[gi] | hit1;
      assign w2_rdy[gi] = s2_rdy_reg[gi] | hit2;
      assign w1_val[gi] = hit1 ? in_cdb_val : s1_val_reg[gi];
      assign w2_val[gi] = hit2 ? in_cdb_val : s2_val_reg[gi];
      // Readiness uses registered state only, so a wakeup issues a cycle later.
      assign ent_ready[gi] = (OCC_W'(gi) < occ_reg) & s1_rdy_reg[gi] & s2_rdy_reg[gi];
    end
  endgenerate

  // Dispatch-time bypass of a CDB broadcast for a not-yet-ready source.
  assign d1_rdy = in_disp_src1_rdy | (in_cdb_valid & (in_disp_src1_tag == in_cdb_tag));
  assign d2_rdy = in_disp_src2_rdy | (in_cdb_valid & (in_disp_src2_tag == in_cdb_tag));
  assign d1_val = in_disp_src1_rdy ? in_disp_src1_val : in_cdb_val;
  assign d2_val = in_disp_src2_rdy ? in_disp_src2_val : in_cdb_val;

  assign out_disp_ready = (occ_reg < OCC_W'(RS_ENTRIES)) & ~in_flush;
  assign disp_fire      = in_disp_valid & out_disp_ready;
  assign sel_fire       = sel_any & (~out_issue_valid | in_issue_ready);
  assign occ_after      = occ_reg - OCC_W'(sel_fire);
  assign occ_next       = occ_after + OCC_W'(disp_fire);
  assign out_occupancy  = occ_reg;

  // Oldest-first select: scan high to low so the lowest ready index wins.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (ent_ready[i]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Next slot contents: compact over the issued slot, then append dispatch at the tail.
  always_comb begin
    int src;
    src = 0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      src = i;
      if (sel_fire && (i >= int'(sel_idx)) && (i < RS_ENTRIES - 1)) src = i + 1;
      op_next[i]     = op_reg[src];
      cc_next[i]     = cc_reg[src];
      dst_next[i]    = dst_reg[src];
      s1_rdy_next[i] = w1_rdy[src];
      s1_tag_next[i] = s1_tag_reg[src];
      s1_val_next[i] = w1_val[src];
      s2_rdy_next[i] = w2_rdy[src];
      s2_tag_next[i] = s2_tag_reg[src];
      s2_val_next[i] = w2_val[src];
      if (disp_fire && (OCC_W'(i) == occ_after)) begin
        op_next[i]     = in_disp_alu_op;
        cc_next[i]     = in_disp_set_cc;
        dst_next[i]    = in_disp_dst_tag;
        s1_rdy_next[i] = d1_rdy;
        s1_tag_next[i] = in_disp_src1_tag;
        s1_val_next[i] = d1_val;
        s2_rdy_next[i] = d2_rdy;
        s2_tag_next[i] = in_disp_src2_tag;
        s2_val_next[i] = d2_val;
      end
    end
  end

  // Station state register; flush empties the queue and drops same-cycle traffic.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      occ_reg <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        op_reg[i]     <= '0;
        cc_reg[i]     <= 1'b0;
        dst_reg[i]    <= '0;
        s1_rdy_reg[i] <= 1'b0;
        s1_tag_reg[i] <= '0;
        s1_val_reg[i] <= '0;
        s2_rdy_reg[i] <= 1'b0;
        s2_tag_reg[i] <= '0;
        s2_val_reg[i] <= '0;
      end
    end else if (in_flush) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        op_reg[i]     <= op_next[i];
        cc_reg[i]     <= cc_next[i];
        dst_reg[i]    <= dst_next[i];
        s1_rdy_reg[i] <= s1_rdy_next[i];
        s1_tag_reg[i] <= s1_tag_next[i];
        s1_val_reg[i] <= s1_val_next[i];
        s2_rdy_reg[i] <= s2_rdy_next[i];
        s2_tag_reg[i] <= s2_tag_next[i];
        s2_val_reg[i] <= s2_val_next[i];
      end
    end
  end

  // Issue register: load on select, hold while stalled, clear when drained.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_issue_valid   <= 1'b0;
      out_issue_alu_op  <= '0;
      out_issue_set_cc  <= 1'b0;
      out_issue_dst_tag <= '0;
      out_issue_val_a   <= '0;
      out_issue_val_b   <= '0;
    end else if (in_flush) begin
      out_issue_valid <= 1'b0;
    end else if (sel_fire) begin
      out_issue_valid   <= 1'b1;
      out_issue_alu_op  <= op_reg[sel_idx];
      out_issue_set_cc  <= cc_reg[sel_idx];
      out_issue_dst_tag <= dst_reg[sel_idx];
      out_issue_val_a   <= s1_val_reg[sel_idx];
      out_issue_val_b   <= s2_val_reg[sel_idx];
    end else if (in_issue_ready) begin
      out_issue_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Reservation-station scheduler between decode/rename and the single ALU in the Tomasulo core. Holds up to `RS_ENTRIES` decoded ALU operations and captures operand values broadcast on the CDB. Each cycle it picks the oldest entry whose operands are both ready and issues it to the ALU through a registered valid/ready handshake. It owns ALU sharing: the ALU sees at most one operation in flight from this block.

## Interface
- `RS_ENTRIES`, 4, number of station entries (2..8)
- `TAG_WIDTH`, 4, ROB/physical tag width
- `VAL_WIDTH`, 64, operand width
- `in_clk`  input  1  clock, rising edge
- `in_rst_n`  input  1  reset; one clock, asynchronous and active-low
- `in_flush`  input  1  synchronous squash of all held state
- `in_disp_valid`  input  1  dispatch request
- `out_disp_ready`  output  1  station can accept
- `in_disp_alu_op`  input  alu_op_t  ALU operation from decode
- `in_disp_set_cc`  input  1  op writes condition codes
- `in_disp_dst_tag`  input  TAG_WIDTH  result tag
- `in_disp_src1_rdy`, `in_disp_src2_rdy`  input  1 each  operand value already valid
- `in_disp_src1_tag`, `in_disp_src2_tag`  input  TAG_WIDTH each  producer tag when not ready
- `in_disp_src1_val`, `in_disp_src2_val`  input  VAL_WIDTH each  operand value when ready
- `in_cdb_valid`  input  1  CDB broadcast
- `in_cdb_tag`  input  TAG_WIDTH  broadcast tag
- `in_cdb_val`  input  VAL_WIDTH  broadcast value
- `out_issue_valid`  output  1  issue register holds an op
- `in_issue_ready`  input  1  ALU accepts
- `out_issue_alu_op`  output  alu_op_t  issued op
- `out_issue_set_cc`  output  1  issued set_CC
- `out_issue_dst_tag`  output  TAG_WIDTH  issued tag
- `out_issue_val_a`, `out_issue_val_b`  output  VAL_WIDTH each  operand values
- `out_occupancy`  output  $clog2(RS_ENTRIES+1)  valid entry count

## Operation
- Storage is a compacting queue. Entry 0 is the oldest. A dispatch writes to slot `occupancy` (after removal, see below).
- Entry fields: alu_op, set_cc, dst_tag, and per source {rdy, tag, val}.
- `out_disp_ready` = occupancy < RS_ENTRIES and not `in_flush`. A full station does not accept in a cycle where it issues.
- Dispatch fires on `in_disp_valid & out_disp_ready`.
- Wakeup: on `in_cdb_valid`, every held source with rdy=0 and tag == `in_cdb_tag` sets rdy=1 and val=`in_cdb_val`.
- Dispatch bypass: an incoming source with rdy=0 and tag == `in_cdb_tag` while `in_cdb_valid` is stored as ready with the CDB value.
- Ready entry: valid, src1.rdy and src2.rdy, all read from registered state. An entry woken this cycle becomes ready next cycle.
- Select: the lowest-index ready entry is chosen when the issue register is empty or draining (`out_issue_valid & in_issue_ready`).
- The selected entry loads into the issue register. Entries above it shift down one slot, carrying same-cycle CDB wakeups with them. A same-cycle dispatch lands at the new tail.
- The issue register holds all outputs stable while `out_issue_valid & !in_issue_ready`. It clears when drained with no new select.
- Flush: at the next edge, all entries are invalid, occupancy is 0 and `out_issue_valid` is 0. Any dispatch and CDB in that cycle are dropped.
- Reset values: all entries invalid, `out_occupancy`=0, `out_issue_valid`=0, `out_issue_*` data=0, `out_disp_ready`=1 after reset release.

## Timing
- Dispatch with both operands ready at edge N: the entry is valid after edge N, selected in cycle N+1, and `out_issue_valid`=1 after edge N+1. Minimum dispatch-to-issue latency is 2 cycles.
- CDB wakeup at edge N: the entry is selectable in cycle N+1 and issues after edge N+1.
- Throughput is one issue per cycle while the ALU holds `in_issue_ready`=1 and ready entries exist.
- `out_occupancy` is registered and counts station entries only, not the issue register.
- Simultaneous dispatch, issue and CDB in one cycle are all honoured at the same edge.
- Asynchronous reset mid-stall drops the held op immediately; outputs take reset values without waiting for a clock edge.

## Test plan
- Reset, then dispatch ADD (alu_op=ALU_OP_PLUS, both rdy, vals 5 and 7, tag 3) with ready=1 -> `out_issue_valid` 2 cycles later with val_a=5, val_b=7, dst_tag=3; occupancy returns to 0.
- Dispatch A (src1 waiting on tag 9), then B (both ready); CDB tag 9 val 0x10 two cycles later -> B issues first, A issues the cycle after the wakeup with val_a=0x10.
- Fill 4 entries with ALU ready=0 -> `out_disp_ready`=0 and issue outputs stable for 5 cycles; raise ready -> entries drain oldest-first, one per cycle.
- Dispatch with src2 tag 6 not ready while CDB broadcasts tag 6 val 0xAB in the same cycle -> entry issues without a further CDB, val_b=0xAB.
- Flush with 3 entries held plus a stalled issue register -> next cycle occupancy=0 and `out_issue_valid`=0; a later CDB of an old tag causes no issue.
- Assert `in_rst_n` low between clock edges during a stall -> `out_issue_valid` falls immediately and `out_occupancy`=0.
